// File: rtl/cache_call_responder_pkg.sv
// ---------------------------------------------------------------------------
// cache_call_responder_pkg
//   Definitions shared by the cache call queue and its responder.
//   Contents:
//     state_t      - responder FSM states (2-bit encoding)
//     ADDR_W_DEF   - default address width
//     DATA_W_DEF   - default data width
//     EMPTY_HEAD   - queue-head value meaning "queue empty"
// ---------------------------------------------------------------------------
package cache_call_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_RESP  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    // A zero head address is how the queue says it has nothing to offer.
    localparam int EMPTY_HEAD = 0;

endpackage

// File: rtl/cache_call_responder_timeout.sv
// ---------------------------------------------------------------------------
// resp_timeout_counter
//   Counts cycles spent waiting on memory and flags the last allowed cycle.
//   Ports:
//     i_clk     in   system clock, rising edge
//     i_rst_n   in   asynchronous active-low reset
//     i_clear   in   force the count back to zero
//     i_enable  in   advance the count by one
//     o_expire  out  high while the count sits on TIMEOUT-1
// ---------------------------------------------------------------------------
module resp_timeout_counter #(
    parameter int TIMEOUT = 255
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_count;

    // Wait-cycle counter: cleared outside the request phase, advanced
    // once per cycle that memory leaves the request unanswered.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    // The count reads zero in the first waiting cycle, so TIMEOUT-1 marks
    // the TIMEOUT-th cycle without an answer.
    assign o_expire = (r_count == LAST);

endmodule

// File: rtl/cache_call_responder.sv
// ---------------------------------------------------------------------------
// cache_call_responder
//   Consumer end of the cache call queue. Issues one memory read per queued
//   head address, returns the data tagged with rs1 to writeback, and pulses
//   done so the queue advances. One request in flight at a time.
//   Ports:
//     i_clk         in   system clock, rising edge
//     i_rst_n       in   asynchronous active-low reset
//     i_call_any    in   queue head address, 0 = queue empty
//     i_rs1         in   queue head destination tag
//     i_mem_ready   in   memory completes the current read this cycle
//     i_mem_rdata   in   read data, valid with i_mem_ready
//     o_mem_req     out  read request, held until i_mem_ready sampled high
//     o_mem_addr    out  latched request address
//     o_done        out  1-cycle pulse, head entry consumed
//     o_wb_valid    out  1-cycle pulse coincident with o_done
//     o_wb_rd       out  latched rs1 of the completed request
//     o_wb_data     out  read data (0 on timeout)
//     o_wb_err      out  1-cycle pulse with o_done on timeout
//     o_served_cnt  out  completed-request count (wraps, includes errors)
// ---------------------------------------------------------------------------
module cache_call_responder
    import cache_call_responder_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 255,
    parameter int DRAIN   = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [ADDR_W-1:0] i_call_any,
    input  logic [4:0]        i_rs1,
    input  logic              i_mem_ready,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_mem_req,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_done,
    output logic              o_wb_valid,
    output logic [4:0]        o_wb_rd,
    output logic [DATA_W-1:0] o_wb_data,
    output logic              o_wb_err,
    output logic [15:0]       o_served_cnt
);

    localparam int DRAIN_W = $clog2(DRAIN + 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN - 1);

    state_t              r_state;
    state_t              w_stateNext;
    logic [DRAIN_W-1:0]  r_drainCnt;
    logic [DRAIN_W-1:0]  w_drainCntNext;
    logic                r_memReq,    w_memReqNext;
    logic [ADDR_W-1:0]   r_memAddr,   w_memAddrNext;
    logic                r_done,      w_doneNext;
    logic                r_wbErr,     w_wbErrNext;
    logic [4:0]          r_wbRd,      w_wbRdNext;
    logic [DATA_W-1:0]   r_wbData,    w_wbDataNext;
    logic [15:0]         r_servedCnt, w_servedCntNext;
    logic                w_headValid;
    logic                w_timerExpire;
    logic                w_complete;

    assign w_headValid = (i_call_any != ADDR_W'(EMPTY_HEAD));
    assign w_complete  = i_mem_ready || w_timerExpire;

    resp_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_clear  (r_state != ST_REQ),
        .i_enable ((r_state == ST_REQ) && !i_mem_ready),
        .o_expire (w_timerExpire)
    );

    // State and output registers. Reset abandons any in-flight request
    // without completing it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_drainCnt  <= '0;
            r_memReq    <= 1'b0;
            r_memAddr   <= '0;
            r_done      <= 1'b0;
            r_wbErr     <= 1'b0;
            r_wbRd      <= '0;
            r_wbData    <= '0;
            r_servedCnt <= '0;
        end else begin
            r_state     <= w_stateNext;
            r_drainCnt  <= w_drainCntNext;
            r_memReq    <= w_memReqNext;
            r_memAddr   <= w_memAddrNext;
            r_done      <= w_doneNext;
            r_wbErr     <= w_wbErrNext;
            r_wbRd      <= w_wbRdNext;
            r_wbData    <= w_wbDataNext;
            r_servedCnt <= w_servedCntNext;
        end
    end

    // Next-state logic. The drain phase keeps the stale queue head, which
    // only refreshes a couple of cycles after done, from being re-issued.
    always_comb begin
        w_stateNext = r_state;
        unique case (r_state)
            ST_IDLE:  if (w_headValid) w_stateNext = ST_REQ;
            ST_REQ:   if (w_complete) w_stateNext = ST_RESP;
            ST_RESP:  w_stateNext = ST_DRAIN;
            ST_DRAIN: if (r_drainCnt == DRAIN_LAST) w_stateNext = ST_IDLE;
            default:  w_stateNext = ST_IDLE;
        endcase
    end

    // Next values for the registered outputs. Completion results are loaded
    // on the REQ->RESP transition so done, wb_* and the new count all appear
    // together in the RESP cycle. Ready data beats a same-cycle timeout.
    always_comb begin
        w_drainCntNext  = '0;
        w_memReqNext    = r_memReq;
        w_memAddrNext   = r_memAddr;
        w_doneNext      = 1'b0;
        w_wbErrNext     = 1'b0;
        w_wbRdNext      = r_wbRd;
        w_wbDataNext    = r_wbData;
        w_servedCntNext = r_servedCnt;
        unique case (r_state)
            ST_IDLE: begin
                if (w_headValid) begin
                    w_memAddrNext = i_call_any;
                    w_wbRdNext    = i_rs1;
                    w_memReqNext  = 1'b1;
                end
            end
            ST_REQ: begin
                if (w_complete) begin
                    w_memReqNext    = 1'b0;
                    w_doneNext      = 1'b1;
                    w_servedCntNext = r_servedCnt + 16'd1;
                    if (i_mem_ready) begin
                        w_wbDataNext = i_mem_rdata;
                    end else begin
                        w_wbDataNext = '0;
                        w_wbErrNext  = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (r_drainCnt != DRAIN_LAST) begin
                    w_drainCntNext = r_drainCnt + DRAIN_W'(1);
                end
            end
            default: ;
        endcase
    end

    assign o_mem_req    = r_memReq;
    assign o_mem_addr   = r_memAddr;
    assign o_done       = r_done;
    assign o_wb_valid   = r_done;
    assign o_wb_rd      = r_wbRd;
    assign o_wb_data    = r_wbData;
    assign o_wb_err     = r_wbErr;
    assign o_served_cnt = r_servedCnt;

endmodule

// File: tb/tb_cache_call_responder.sv
// ---------------------------------------------------------------------------
// tb_cache_call_responder
//   Drives a queue-of-calls model and a randomised memory in front of
//   cache_call_responder and checks each completed transaction against
//   expectations computed from the entry and the memory's chosen wait.
// ---------------------------------------------------------------------------
module tb_cache_call_responder;

    localparam int TIMEOUT = 6;
    localparam int DRAIN   = 1;

    typedef struct {
        logic [31:0] addr;
        logic [4:0]  rd;
        int          waitCyc;
        logic [31:0] data;
    } entry_t;

    logic        clk = 1'b0;
    logic        i_rst_n;
    logic [31:0] i_call_any;
    logic [4:0]  i_rs1;
    logic        i_mem_ready;
    logic [31:0] i_mem_rdata;
    logic        o_mem_req;
    logic [31:0] o_mem_addr;
    logic        o_done;
    logic        o_wb_valid;
    logic [4:0]  o_wb_rd;
    logic [31:0] o_wb_data;
    logic        o_wb_err;
    logic [15:0] o_served_cnt;

    int     totalChecks = 0;
    int     badChecks   = 0;
    int     cycle       = 0;
    int     headCycle   = 0;
    int     popCountdown = 0;
    int     reqCycles   = 0;
    int     curWait     = 0;
    int     expServed   = 0;
    bit     reqActive   = 0;
    bit     prevDone    = 0;
    entry_t pending[$];

    cache_call_responder #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (TIMEOUT),
        .DRAIN   (DRAIN)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (i_rst_n),
        .i_call_any   (i_call_any),
        .i_rs1        (i_rs1),
        .i_mem_ready  (i_mem_ready),
        .i_mem_rdata  (i_mem_rdata),
        .o_mem_req    (o_mem_req),
        .o_mem_addr   (o_mem_addr),
        .o_done       (o_done),
        .o_wb_valid   (o_wb_valid),
        .o_wb_rd      (o_wb_rd),
        .o_wb_data    (o_wb_data),
        .o_wb_err     (o_wb_err),
        .o_served_cnt (o_served_cnt)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, observed, expected, cycle);
        end
    endtask

    // Put the current queue head (or the empty marker) on the call inputs.
    task automatic presentHead();
        if (pending.size() > 0) begin
            i_call_any = pending[0].addr;
            i_rs1      = pending[0].rd;
            headCycle  = cycle;
        end else begin
            i_call_any = 32'h0;
            i_rs1      = 5'($urandom);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] addr, input logic [4:0] rd,
                                 input int waitCyc, input logic [31:0] data);
        entry_t e;
        e.addr    = addr;
        e.rd      = rd;
        e.waitCyc = waitCyc;
        e.data    = data;
        pending.push_back(e);
        if (pending.size() == 1 && popCountdown == 0) presentHead();
    endtask

    // One clock: advance the queue model, check completions, play memory.
    task automatic stepCycle();
        entry_t e;
        bit     expErr;
        int     expLen;
        @(posedge clk);
        #1;
        cycle++;

        // The queue head refreshes two cycles after the done pulse.
        if (popCountdown > 0) begin
            popCountdown--;
            if (popCountdown == 0) begin
                if (pending.size() > 0) pending.delete(0);
                presentHead();
            end
        end

        if (o_done) begin
            checkOutput("done_back_to_back", 64'(prevDone), 64'd0);
            if (!reqActive || pending.size() == 0) begin
                checkOutput("unexpected_done", 64'(o_done), 64'd0);
            end else begin
                e      = pending[0];
                expErr = (curWait + 1 > TIMEOUT);
                expLen = expErr ? TIMEOUT : curWait + 1;
                expServed = (expServed + 1) % 65536;
                checkOutput("wb_valid", 64'(o_wb_valid), 64'd1);
                checkOutput("wb_rd", 64'(o_wb_rd), 64'(e.rd));
                checkOutput("wb_data", 64'(o_wb_data), expErr ? 64'd0 : 64'(e.data));
                checkOutput("wb_err", 64'(o_wb_err), 64'(expErr));
                checkOutput("req_cycles", 64'(reqCycles), 64'(expLen));
                checkOutput("done_latency", 64'(cycle - headCycle), 64'(1 + expLen));
                checkOutput("served_cnt", 64'(o_served_cnt), 64'(expServed));
                reqActive    = 0;
                popCountdown = 2;
            end
        end else begin
            checkOutput("pulse_without_done", {62'd0, o_wb_valid, o_wb_err}, 64'd0);
        end
        prevDone = o_done;

        if (o_mem_req) begin
            if (!reqActive) begin
                if (pending.size() == 0) begin
                    checkOutput("req_while_empty", 64'(o_mem_req), 64'd0);
                end else begin
                    reqActive = 1;
                    reqCycles = 0;
                    curWait   = pending[0].waitCyc;
                    checkOutput("mem_addr", 64'(o_mem_addr), 64'(pending[0].addr));
                    checkOutput("req_start_latency", 64'(cycle - headCycle), 64'd1);
                end
            end else begin
                checkOutput("addr_stable", 64'(o_mem_addr), 64'(pending[0].addr));
            end
        end else if (reqActive) begin
            checkOutput("req_dropped_early", 64'(o_mem_req), 64'd1);
            reqActive = 0;
        end

        if (o_mem_req && reqActive) begin
            reqCycles++;
            i_mem_ready = (reqCycles == curWait + 1);
            i_mem_rdata = i_mem_ready ? pending[0].data : $urandom;
        end else begin
            // Stray ready pulses with no request outstanding must be ignored.
            i_mem_ready = ($urandom_range(0, 3) == 0);
            i_mem_rdata = $urandom;
        end
    endtask

    // Run until the queue is empty and nothing is in flight, within a budget.
    task automatic runUntilIdle(input int maxCycles);
        int n = 0;
        while ((pending.size() > 0 || reqActive || popCountdown > 0) && n < maxCycles) begin
            stepCycle();
            n++;
        end
        if (n >= maxCycles) checkOutput("idle_budget", 64'(pending.size()), 64'd0);
        repeat (3) stepCycle();
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] addr;
        i_rst_n     = 1'b0;
        i_call_any  = 32'h0;
        i_rs1       = 5'd0;
        i_mem_ready = 1'b0;
        i_mem_rdata = 32'h0;

        // Reset held for three cycles, then idle with an empty queue.
        repeat (3) stepCycle();
        checkOutput("reset_ctrl", {57'd0, o_mem_req, o_done, o_wb_valid, o_wb_err, o_wb_rd[2:0]}, 64'd0);
        checkOutput("reset_addr_data", {o_mem_addr, o_wb_data}, 64'd0);
        checkOutput("reset_rd_cnt", {43'd0, o_wb_rd, o_served_cnt}, 64'd0);
        #2;
        i_rst_n = 1'b1;
        repeat (10) begin
            stepCycle();
            checkOutput("idle_mem_req", 64'(o_mem_req), 64'd0);
        end

        // Zero-wait read.
        applyStimulus(32'h0000_0044, 5'd17, 0, 32'hDEAD_BEEF);
        runUntilIdle(50);

        // Five wait cycles: ready lands on the last allowed cycle, data wins.
        applyStimulus(32'h0000_0100, 5'd3, 5, 32'h1234_5678);
        runUntilIdle(50);

        // Memory never answers: error completion after TIMEOUT cycles.
        applyStimulus(32'h0000_0200, 5'd9, 1000, 32'hFFFF_FFFF);
        runUntilIdle(50);

        // Back-to-back queue entries, tag derived from the address.
        applyStimulus(32'h10, 5'd4, 0, 32'hA0A0_0010);
        applyStimulus(32'h20, 5'd8, 1, 32'hA0A0_0020);
        applyStimulus(32'h30, 5'd12, 0, 32'hA0A0_0030);
        runUntilIdle(100);

        // Randomised bursts of queue entries and memory waits.
        for (int r = 0; r < 40; r++) begin
            for (int k = 0; k < int'($urandom_range(1, 4)); k++) begin
                addr = $urandom;
                if (addr == 32'h0) addr = 32'h4;
                applyStimulus(addr, 5'($urandom), int'($urandom_range(0, 8)), $urandom);
            end
            runUntilIdle(300);
            repeat ($urandom_range(0, 3)) stepCycle();
        end

        // Reset in the middle of a request: abandoned, then served once.
        applyStimulus(32'h0000_1234, 5'd21, 3, 32'hCAFE_F00D);
        stepCycle();
        stepCycle();
        #2;
        i_rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_mem_req", 64'(o_mem_req), 64'd0);
        checkOutput("rst_mid_done", 64'(o_done), 64'd0);
        checkOutput("rst_mid_served", 64'(o_served_cnt), 64'd0);
        reqActive   = 0;
        expServed   = 0;
        prevDone    = 0;
        i_mem_ready = 1'b0;
        repeat (2) stepCycle();
        #2;
        i_rst_n   = 1'b1;
        headCycle = cycle;
        runUntilIdle(50);
        repeat (10) stepCycle();
        checkOutput("served_after_reset", 64'(o_served_cnt), 64'd1);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
